// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared types and arithmetic helpers for the Maxnet engine.
//   state_t : controller states
//   clamp0  : signed value -> nonnegative (negatives become zero)
//   update  : one lateral-inhibition step, max(0, a - ((S - a) * eps) >> frac)
// The helpers work at a fixed working width XW. Callers zero- or sign-extend
// their operands into XW and truncate the result back with a size cast.
// This requires W+IW <= XW. The product is formed at 2*XW bits, so it cannot
// overflow.
package maxnet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SUM,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam int unsigned XW = 64;

  function automatic logic [XW-1:0] clamp0(input logic signed [XW-1:0] x);
    return x[XW-1] ? '0 : x;
  endfunction

  // a is nonnegative and S >= a, so the difference and the product are
  // unsigned. The right shift truncates toward zero. The final clamp is a
  // magnitude compare. This gives the same result as a signed subtract
  // followed by a clamp at zero.
  function automatic logic [XW-1:0] update(input logic [XW-1:0] a,
                                           input logic [XW-1:0] s,
                                           input logic [XW-1:0] eps,
                                           input int unsigned   frac);
    logic [2*XW-1:0] prod;
    logic [XW-1:0]   q;
    prod = {{XW{1'b0}}, s - a} * {{XW{1'b0}}, eps};
    q    = XW'(prod >> frac);
    return (q >= a) ? '0 : a - q;
  endfunction

endpackage

// File: rtl/counter_nbit.sv
// counter_nbit: parametrised up-counter that wraps synchronously.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset (count -> 0)
//   i_init   : synchronous clear to 0 (takes priority over i_en)
//   i_en     : count enable. At TERMINAL, the counter wraps to 0.
//   o_count  : current count
//   o_co     : carry-out, high while the count equals TERMINAL
module counter_nbit #(
  parameter int unsigned       WIDTH    = 2,
  parameter logic [WIDTH-1:0]  TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_co
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_init) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_co ? '0 : r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_co    = (r_count == TERMINAL);

endmodule

// File: rtl/maxnet_engine.sv
// maxnet_engine: Maxnet winner-take-all datapath and controller.
// The engine loads N signed activations, then alternates SUM and UPDATE passes
// of lateral inhibition until at most one neuron is nonzero or MAX_ITER is
// reached.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begins a load. It is accepted only in IDLE or DONE.
//   in_valid/in_data: activation stream, in neuron order 0..N-1
//   in_ready        : high in LOAD
//   busy            : high in LOAD, SUM and UPDATE
//   done            : level, high once the result is latched in DONE
//   winner          : index of the surviving neuron (0 if there is none)
//   winner_value    : final activation of the winner (0 if there is none)
//   iter_count      : number of completed UPDATE passes
//   no_winner       : all activations are zero at DONE
//   timeout         : DONE was reached with iter_count == MAX_ITER
module maxnet_engine
  import maxnet_pkg::*;
#(
  parameter int unsigned      N        = 4,
  parameter int unsigned      W        = 32,
  parameter int unsigned      FRAC     = 16,
  parameter logic [FRAC-1:0]  EPS      = 16'h2000,
  parameter int unsigned      MAX_ITER = 255,
  parameter int unsigned      IW       = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [W-1:0]                   in_data,
  output logic                           in_ready,
  output logic                           busy,
  output logic                           done,
  output logic [IW-1:0]                  winner,
  output logic [W-1:0]                   winner_value,
  output logic [$clog2(MAX_ITER+1)-1:0]  iter_count,
  output logic                           no_winner,
  output logic                           timeout
);

  localparam int unsigned CW = $clog2(MAX_ITER + 1);

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_a [N];
  logic [W+IW-1:0] r_s;
  logic [IW:0]     r_nz;
  logic [IW-1:0]   r_last;

  logic            r_done;
  logic            r_timeout;
  logic            r_no_winner;
  logic [IW-1:0]   r_winner;
  logic [W-1:0]    r_winner_value;

  logic [IW-1:0]   w_idx;
  logic            w_idx_co;
  logic [CW-1:0]   w_iter;
  logic            w_iter_co;

  logic            w_start_ok;
  logic            w_idx_en;
  logic            w_iter_en;
  logic [W-1:0]    w_a_cur;
  logic [W-1:0]    w_a_load;
  logic [W-1:0]    w_a_new;
  logic [IW:0]     w_nz_next;
  logic            w_last_sum;
  logic            w_timeout_hit;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_idx_en   = (r_state == ST_LOAD && in_valid) ||
                      (r_state == ST_SUM) || (r_state == ST_UPDATE);
  assign w_iter_en  = (r_state == ST_UPDATE) && w_idx_co;

  assign w_a_cur   = r_a[w_idx];
  assign w_a_load  = W'(clamp0(XW'(signed'(in_data))));
  assign w_a_new   = W'(update(XW'(w_a_cur), XW'(r_s), XW'(EPS), FRAC));
  assign w_nz_next = r_nz + (IW+1)'(w_a_cur != '0);

  // The decision uses the nonzero count including the neuron in the final
  // SUM cycle.
  assign w_last_sum    = (r_state == ST_SUM) && w_idx_co;
  assign w_timeout_hit = w_last_sum && (w_nz_next > (IW+1)'(1)) && w_iter_co;

  counter_nbit #(
    .WIDTH    (IW),
    .TERMINAL (IW'(N - 1))
  ) u_idx_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_init  (w_start_ok),
    .i_en    (w_idx_en),
    .o_count (w_idx),
    .o_co    (w_idx_co)
  );

  counter_nbit #(
    .WIDTH    (CW),
    .TERMINAL (CW'(MAX_ITER))
  ) u_iter_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_init  (w_start_ok),
    .i_en    (w_iter_en),
    .o_count (w_iter),
    .o_co    (w_iter_co)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_LOAD;
      ST_LOAD:   if (in_valid && w_idx_co) w_state_next = ST_SUM;
      ST_SUM: begin
        if (w_idx_co) begin
          if (w_nz_next <= (IW+1)'(1) || w_iter_co) w_state_next = ST_DONE;
          else                                     w_state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: if (w_idx_co) w_state_next = ST_SUM;
      ST_DONE:   if (start) w_state_next = ST_LOAD;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) r_a[i] <= '0;
      r_s            <= '0;
      r_nz           <= '0;
      r_last         <= '0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
      r_no_winner    <= 1'b0;
      r_winner       <= '0;
      r_winner_value <= '0;
    end else begin
      if (w_start_ok) begin
        r_done         <= 1'b0;
        r_timeout      <= 1'b0;
        r_no_winner    <= 1'b0;
        r_winner       <= '0;
        r_winner_value <= '0;
      end else if (r_state == ST_DONE && !r_done) begin
        // The result is latched on the first DONE cycle. Any nz >= 2
        // (a timeout) reports winner 0 with value 0.
        r_done      <= 1'b1;
        r_no_winner <= (r_nz == '0);
        if (r_nz == (IW+1)'(1)) begin
          r_winner       <= r_last;
          r_winner_value <= r_a[r_last];
        end else begin
          r_winner       <= '0;
          r_winner_value <= '0;
        end
      end

      case (r_state)
        ST_LOAD: begin
          if (in_valid) r_a[w_idx] <= w_a_load;
          r_s    <= '0;
          r_nz   <= '0;
          r_last <= '0;
        end
        ST_SUM: begin
          r_s  <= r_s + (W+IW)'(w_a_cur);
          r_nz <= w_nz_next;
          if (w_a_cur != '0) r_last <= w_idx;
          if (w_timeout_hit) r_timeout <= 1'b1;
        end
        ST_UPDATE: begin
          // r_s holds its value for the whole pass, so each in-place write
          // sees the pre-pass sum. It is cleared only on the final cycle.
          r_a[w_idx] <= w_a_new;
          if (w_idx_co) begin
            r_s    <= '0;
            r_nz   <= '0;
            r_last <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == ST_LOAD);
  assign busy         = (r_state == ST_LOAD) || (r_state == ST_SUM) ||
                        (r_state == ST_UPDATE);
  assign done         = r_done;
  assign winner       = r_winner;
  assign winner_value = r_winner_value;
  assign iter_count   = w_iter;
  assign no_winner    = r_no_winner;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_maxnet_engine.sv
// tb_maxnet_engine: directed self-checking bench for maxnet_engine
// (N=4, W=32, FRAC=16, EPS=0.125, MAX_ITER=255).
module tb_maxnet_engine;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [IW-1:0] winner;
  logic [W-1:0]  winner_value;
  logic [CW-1:0] iter_count;
  logic          no_winner;
  logic          timeout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc;

  maxnet_engine #(
    .N        (4),
    .W        (32),
    .FRAC     (16),
    .EPS      (16'h2000),
    .MAX_ITER (255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_value (winner_value),
    .iter_count   (iter_count),
    .no_winner    (no_winner),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns #1 after the edge that takes the last transfer.
  task automatic load4(input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3,
                       input int g0, input int g1, input int g2, input int g3);
    logic [31:0] v [4];
    int          g [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      for (int k = 0; k < g[i]; k++) begin
        @(posedge clk); #1;
        check("in_ready_stall", in_ready, 1);
      end
      in_data  = v[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Counts the rising edges from the last transfer until done is seen high.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
    if (!done) check("done_wait_expired", 0, 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_iter", iter_count, 0);
    check("rst_winner_value", winner_value, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 1: two nonzero neurons, five iterations
    do_start();
    check("s1_in_ready", in_ready, 1);
    load4(32'h10000, 32'h8000, 32'h0, 32'h0, 0, 0, 0, 0);
    wait_done(cyc);
    check("s1_latency", cyc, 45);
    check("s1_winner", winner, 0);
    check("s1_value", winner_value, 32'hD5CF);
    check("s1_iter", iter_count, 5);
    check("s1_no_winner", no_winner, 0);
    check("s1_timeout", timeout, 0);
    check("s1_busy", busy, 0);

    // 2: single nonzero, immediate winner
    do_start();
    check("s2_done_cleared", done, 0);
    load4(32'h0, 32'h0, 32'h4000, 32'h0, 0, 0, 0, 0);
    wait_done(cyc);
    check("s2_latency", cyc, 5);
    check("s2_winner", winner, 2);
    check("s2_value", winner_value, 32'h4000);
    check("s2_iter", iter_count, 0);

    // 3: all zero
    do_start();
    load4(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    wait_done(cyc);
    check("s3_no_winner", no_winner, 1);
    check("s3_winner", winner, 0);
    check("s3_value", winner_value, 0);
    check("s3_iter", iter_count, 0);

    // 4: tie never resolves -> timeout at MAX_ITER
    do_start();
    check("s4_no_winner_cleared", no_winner, 0);
    load4(32'h10000, 32'h10000, 32'h0, 32'h0, 0, 0, 0, 0);
    wait_done(cyc);
    check("s4_timeout", timeout, 1);
    check("s4_iter", iter_count, 255);
    check("s4_winner", winner, 0);
    check("s4_value", winner_value, 0);
    check("s4_no_winner", no_winner, 0);

    // 5: negatives clamped, valid gaps of 0..3 cycles
    do_start();
    check("s5_timeout_cleared", timeout, 0);
    load4(32'hFFFFFFFB, 32'h100, 32'hFFFFFFFF, 32'h0, 1, 3, 0, 2);
    check("s5_in_ready_sum", in_ready, 0);
    wait_done(cyc);
    check("s5_winner", winner, 1);
    check("s5_value", winner_value, 32'h100);
    check("s5_iter", iter_count, 0);
    check("s5_in_ready_done", in_ready, 0);

    // 6: reset during the second UPDATE pass, then a clean rerun with a stray start
    do_start();
    load4(32'h10000, 32'h8000, 32'h0, 32'h0, 0, 0, 0, 0);
    repeat (14) @(posedge clk);
    #1;
    check("s6_busy_pre", busy, 1);
    check("s6_iter_pre", iter_count, 1);
    rst = 1'b0;
    #2;
    check("s6_rst_busy", busy, 0);
    check("s6_rst_in_ready", in_ready, 0);
    check("s6_rst_done", done, 0);
    check("s6_rst_iter", iter_count, 0);
    check("s6_rst_winner", winner, 0);
    check("s6_rst_value", winner_value, 0);
    check("s6_rst_timeout", timeout, 0);
    check("s6_rst_no_winner", no_winner, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s6_idle", busy, 0);
    do_start();
    load4(32'h10000, 32'h8000, 32'h0, 32'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("s6_winner", winner, 0);
    check("s6_value", winner_value, 32'hD5CF);
    check("s6_iter", iter_count, 5);
    check("s6_timeout", timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
